icap_reboot_seq: RTL and testbench
==================================

# icap_reboot_seq

Hardware sequencer for the FPGA internal configuration access port (ICAP). On one CSR command it plays the complete multiboot/IPROG word sequence into the ICAP, with correct ICAP clocking and CE/WRITE framing, from a software-programmed warm-boot address. It sits on the CSR bus next to sysctl. It replaces bit-banging the ICAP data, CE, WRITE and clock lines through a CSR with software delays between writes.

## Interface
Parameters:
- csr_addr, 4'h0: CSR bank select, compared with csr_a[13:10].
- clk_div, 4: sys_clk cycles per ICAP clock phase. Legal range is 1..255.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- csr_a  in  14  CSR address; [13:10] bank, [1:0] register.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered.
- icap_clk  out  1  ICAP clock, registered.
- icap_ce_n  out  1  ICAP chip enable, active-low.
- icap_write_n  out  1  ICAP write enable, active-low.
- icap_i  out  16  ICAP data, already bit-swapped by the caller side.
- busy  out  1  sequence in progress.

## Operation
- Registers, selected when csr_a[13:10]==csr_addr:
  - 0 CTRL, write: bit0 = start, bit1 = abort. Read: bit0 = busy, bit1 = done.
  - 1 ADDR, read/write, 24 bits: warm-boot flash address.
  - 2 STAT, read-only: [3:0] current word index.
- FSM states: IDLE, LOW, HIGH.
- Start is accepted only in IDLE.
  - On acceptance, ADDR is snapshotted into an internal register and done is cleared.
  - ADDR writes made during busy update the CSR but not the running sequence.
- Word sequence, idx 0..12: FFFF, AA99, 5566, 3261, addr[15:0], 3281, {8'h03, addr[23:16]}, 30A1, 000E, 2000, 2000, 2000, 2000.
- LOW phase:
  - icap_clk=0, icap_i=word[idx], icap_ce_n=0, icap_write_n=0.
  - Lasts clk_div cycles, then goes to HIGH.
- HIGH phase:
  - icap_clk=1, data and controls held.
  - Lasts clk_div cycles.
  - Then, if idx==12: go to IDLE with ce_n=1, write_n=1, icap_clk=0, icap_i=FFFF, done=1.
  - Otherwise: idx+1 and back to LOW.
- Abort is honoured in any state. It forces IDLE at the next edge with outputs at their idle values and done=0.
- Simultaneous start and abort: abort wins and nothing starts.
- A start write in IDLE while done=1 restarts the sequence normally.
- The phase counter is 8 bits and loads clk_div-1. There is no wrap beyond the 12th word.
- csr_do is 0 when the bank is not selected. Writes to other banks are ignored.

## Timing
- Reset values (asynchronous):
  - state=IDLE, idx=0, busy=0, done=0, ADDR=0, csr_do=0.
  - icap_clk=0, icap_ce_n=1, icap_write_n=1, icap_i=FFFF.
- Start write sampled at edge T:
  - Edge T: LOW entered. busy, icap_ce_n=0 and icap_i=FFFF are visible after T.
  - First icap_clk rise is at edge T+clk_div.
- Each word occupies 2*clk_div cycles, and data is stable for clk_div cycles either side of the icap_clk rise.
- Total busy time is 26*clk_div cycles. busy falls and done rises on the same edge.
- CSR read latency is 1 cycle. Status reflects register state before the edge.
- Asynchronous reset mid-sequence returns all outputs to idle immediately, without waiting for a clock edge.

## Structure
- Package icap_pkg holds:
  - the FSM state enum;
  - the ICAP word constants: DUMMY, SYNC1, SYNC2, WR_GEN1, WR_GEN2, WR_CMD, CMD_IPROG, NOOP, READ_OP;
  - the last index, 12.
- One sub-module, icap_seq_rom: combinational (idx, addr) to 16-bit word. It is kept separate so it can be exhaustively checked.
- The FSM, phase counter and CSR decode live in icap_reboot_seq.

## Test plan
- Reset:
  - Assert sys_rst → icap_ce_n=1, icap_write_n=1, icap_clk=0, icap_i=FFFF, busy=0.
  - CSR reads of registers 0/1/2 → 0.
- Full sequence:
  - clk_div=4, ADDR=0x123456, CTRL=1.
  - Words sampled on icap_clk rise → FFFF AA99 5566 3261 3456 3281 0312 30A1 000E 2000 2000 2000 2000.
  - busy high for exactly 104 cycles; CTRL then reads 2.
- Ignore during busy:
  - Second CTRL=1 and ADDR=0xABCDEF written while idx=2.
  - Expect word 4 = 3456, total length unchanged, ADDR readback = 0xABCDEF.
- Abort:
  - CTRL=2 while idx=5 → next edge gives busy=0, icap_ce_n=1, icap_i=FFFF, CTRL reads 0.
  - CTRL=3 from IDLE → no activity.
- Asynchronous reset:
  - Pulse sys_rst between clock edges during idx=7.
  - Outputs reach idle values before the next sys_clk edge; a fresh start then produces the full sequence again.
- Minimum divider and bank select:
  - clk_div=1 → icap_clk toggles every cycle, busy lasts 26 cycles.
  - Access with csr_a[13:10]≠csr_addr → csr_do=0, no start.

Source files
------------

// File: rtl/icap_pkg.sv
// Shared types and ICAP command words for the multiboot/IPROG reboot sequencer.
package icap_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   localparam logic [15:0] DUMMY     = 16'hFFFF;
   localparam logic [15:0] SYNC1     = 16'hAA99;
   localparam logic [15:0] SYNC2     = 16'h5566;
   localparam logic [15:0] WR_GEN1   = 16'h3261;
   localparam logic [15:0] WR_GEN2   = 16'h3281;
   localparam logic [15:0] WR_CMD    = 16'h30A1;
   localparam logic [15:0] CMD_IPROG = 16'h000E;
   localparam logic [15:0] NOOP      = 16'h2000;
   localparam logic [15:0] READ_OP   = 16'h2800;

   localparam logic [3:0] LAST_IDX = 4'd12;

endpackage

// File: rtl/icap_seq_rom.sv
// Combinational word table: maps sequence index and warm-boot address to the ICAP word.
module icap_seq_rom
   import icap_pkg::*;
(
   input  logic [3:0]  idx,
   input  logic [23:0] addr,
   output logic [15:0] word
);

   always_comb begin
      word = NOOP;
      case (idx)
         4'd0:    word = DUMMY;
         4'd1:    word = SYNC1;
         4'd2:    word = SYNC2;
         4'd3:    word = WR_GEN1;
         4'd4:    word = addr[15:0];
         4'd5:    word = WR_GEN2;
         4'd6:    word = {8'h03, addr[23:16]};
         4'd7:    word = WR_CMD;
         4'd8:    word = CMD_IPROG;
         default: word = NOOP;
      endcase
   end

endmodule

// File: rtl/icap_reboot_seq.sv
// CSR-driven ICAP reboot sequencer: plays the IPROG word stream with a divided ICAP clock.
module icap_reboot_seq
   import icap_pkg::*;
#(
   parameter logic [3:0] csr_addr = 4'h0,
   parameter int         clk_div  = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic        icap_clk,
   output logic        icap_ce_n,
   output logic        icap_write_n,
   output logic [15:0] icap_i,
   output logic        busy
);

   localparam logic [7:0] div_load = 8'(clk_div - 1);

   state_t      state, state_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        done, done_nxt;
   logic [23:0] addr_csr;
   logic [23:0] addr_run, addr_run_nxt;
   logic        clk_nxt, ce_n_nxt, write_n_nxt;
   logic [15:0] rom_word;
   logic [15:0] data_nxt;

   logic sel, ctrl_wr, addr_wr, start_req, abort_req;

   assign sel       = (csr_a[13:10] == csr_addr);
   assign ctrl_wr   = sel && csr_we && (csr_a[1:0] == 2'd0);
   assign addr_wr   = sel && csr_we && (csr_a[1:0] == 2'd1);
   assign start_req = ctrl_wr && csr_di[0];
   assign abort_req = ctrl_wr && csr_di[1];

   logic unused_bits;
   assign unused_bits = &{1'b0, csr_a[9:2], csr_di[31:24]};

   assign busy = (state != IDLE);

   // Word lookup uses next-cycle index/address so icap_i changes on the same edge as the phase.
   icap_seq_rom u_rom (
      .idx  (idx_nxt),
      .addr (addr_run_nxt),
      .word (rom_word)
   );

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      cnt_nxt      = cnt;
      done_nxt     = done;
      addr_run_nxt = addr_run;
      clk_nxt      = icap_clk;
      ce_n_nxt     = icap_ce_n;
      write_n_nxt  = icap_write_n;
      if (abort_req) begin
         state_nxt   = IDLE;
         idx_nxt     = 4'd0;
         done_nxt    = 1'b0;
         clk_nxt     = 1'b0;
         ce_n_nxt    = 1'b1;
         write_n_nxt = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start_req) begin
                  state_nxt    = LOW;
                  idx_nxt      = 4'd0;
                  cnt_nxt      = div_load;
                  done_nxt     = 1'b0;
                  addr_run_nxt = addr_csr;
                  clk_nxt      = 1'b0;
                  ce_n_nxt     = 1'b0;
                  write_n_nxt  = 1'b0;
               end
            end
            LOW: begin
               if (cnt == 8'd0) begin
                  state_nxt = HIGH;
                  cnt_nxt   = div_load;
                  clk_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt - 8'd1;
               end
            end
            HIGH: begin
               if (cnt == 8'd0) begin
                  if (idx == LAST_IDX) begin
                     state_nxt   = IDLE;
                     done_nxt    = 1'b1;
                     clk_nxt     = 1'b0;
                     ce_n_nxt    = 1'b1;
                     write_n_nxt = 1'b1;
                  end else begin
                     state_nxt = LOW;
                     idx_nxt   = idx + 4'd1;
                     cnt_nxt   = div_load;
                     clk_nxt   = 1'b0;
                  end
               end else begin
                  cnt_nxt = cnt - 8'd1;
               end
            end
            default: begin
               state_nxt   = IDLE;
               clk_nxt     = 1'b0;
               ce_n_nxt    = 1'b1;
               write_n_nxt = 1'b1;
            end
         endcase
      end
      data_nxt = (state_nxt == IDLE) ? DUMMY : rom_word;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= IDLE;
         idx          <= 4'd0;
         cnt          <= 8'd0;
         done         <= 1'b0;
         addr_run     <= 24'd0;
         icap_clk     <= 1'b0;
         icap_ce_n    <= 1'b1;
         icap_write_n <= 1'b1;
         icap_i       <= DUMMY;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         cnt          <= cnt_nxt;
         done         <= done_nxt;
         addr_run     <= addr_run_nxt;
         icap_clk     <= clk_nxt;
         icap_ce_n    <= ce_n_nxt;
         icap_write_n <= write_n_nxt;
         icap_i       <= data_nxt;
      end
   end

   // CSR side: ADDR may be rewritten at any time; the running sequence uses its own snapshot.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         addr_csr <= 24'd0;
         csr_do   <= 32'd0;
      end else begin
         if (addr_wr) begin
            addr_csr <= csr_di[23:0];
         end
         csr_do <= 32'd0;
         if (sel) begin
            case (csr_a[1:0])
               2'd0:    csr_do <= {30'd0, done, busy};
               2'd1:    csr_do <= {8'd0, addr_csr};
               2'd2:    csr_do <= {28'd0, idx};
               default: csr_do <= 32'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_icap_reboot_seq.sv
// Scoreboard bench: stimulus queues expected ICAP words, a monitor checks them at each icap_clk rise.
module tb_icap_reboot_seq;

   logic        sys_clk;
   logic        sys_rst;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;

   logic [31:0] do4, do1;
   logic        icap_clk4, ce_n4, wr_n4, busy4;
   logic        icap_clk1, ce_n1, wr_n1, busy1;
   logic [15:0] icap_i4, icap_i1;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q[$];
   logic        prev_clk4 = 1'b0;

   icap_reboot_seq #(.csr_addr(4'h0), .clk_div(4)) dut4 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
      .csr_di(csr_di), .csr_do(do4), .icap_clk(icap_clk4), .icap_ce_n(ce_n4),
      .icap_write_n(wr_n4), .icap_i(icap_i4), .busy(busy4)
   );

   icap_reboot_seq #(.csr_addr(4'h3), .clk_div(1)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
      .csr_di(csr_di), .csr_do(do1), .icap_clk(icap_clk1), .icap_ce_n(ce_n1),
      .icap_write_n(wr_n1), .icap_i(icap_i1), .busy(busy1)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Hand-written word lists: set 0 is ADDR=0x123456, set 1 is ADDR=0xABCDEF.
   function automatic logic [15:0] exp_word(input int set, input int i);
      logic [15:0] w;
      case (i)
         0:  w = 16'hFFFF;
         1:  w = 16'hAA99;
         2:  w = 16'h5566;
         3:  w = 16'h3261;
         4:  w = (set == 0) ? 16'h3456 : 16'hCDEF;
         5:  w = 16'h3281;
         6:  w = (set == 0) ? 16'h0312 : 16'h03AB;
         7:  w = 16'h30A1;
         8:  w = 16'h000E;
         default: w = 16'h2000;
      endcase
      return w;
   endfunction

   task automatic push_words(input int set, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(exp_word(set, i));
   endtask

   function automatic logic [13:0] ca(input logic [3:0] bank, input logic [1:0] r);
      return {bank, 8'h00, r};
   endfunction

   task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      @(negedge sys_clk);
      csr_we = 1'b0;
   endtask

   task automatic csr_rd(input logic [13:0] a);
      csr_a  = a;
      csr_we = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic count_busy4(output int n);
      n = 0;
      while (busy4 && n < 1000) begin
         n++;
         @(negedge sys_clk);
      end
   endtask

   always @(negedge sys_clk) begin
      if (icap_clk4 && !prev_clk4) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none", icap_i4);
         end else begin
            logic [15:0] w;
            w = exp_q.pop_front();
            chk("icap_word", {14'd0, ce_n4, wr_n4, icap_i4}, {16'd0, w});
         end
      end
      prev_clk4 = icap_clk4;
   end

   initial begin
      int n;
      int tog_err;
      sys_rst = 1'b1;
      csr_a   = '0;
      csr_we  = 1'b0;
      csr_di  = '0;

      // Reset state
      #12;
      chk("rst_ctrl", {27'd0, busy4, icap_clk4, ce_n4, wr_n4, 1'b0}, {27'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      chk("rst_data", {16'd0, icap_i4}, 32'h0000FFFF);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      csr_rd(ca(4'h0, 2'd0)); chk("rst_rd_ctrl", do4, 32'd0);
      csr_rd(ca(4'h0, 2'd1)); chk("rst_rd_addr", do4, 32'd0);
      csr_rd(ca(4'h0, 2'd2)); chk("rst_rd_stat", do4, 32'd0);

      // Full sequence with clk_div=4
      csr_wr(ca(4'h0, 2'd1), 32'h00123456);
      push_words(0, 13);
      csr_wr(ca(4'h0, 2'd0), 32'd1);
      chk("start_ce_n", {31'd0, ce_n4}, 32'd0);
      count_busy4(n);
      chk("busy_len_full", n, 104);
      repeat (4) @(negedge sys_clk);
      chk("words_full", exp_q.size(), 0);
      csr_rd(ca(4'h0, 2'd0)); chk("done_full", do4, 32'd2);

      // Start and ADDR writes ignored by the running sequence
      push_words(0, 13);
      csr_wr(ca(4'h0, 2'd0), 32'd1);
      fork
         begin
            count_busy4(n);
            chk("busy_len_ignore", n, 104);
         end
         begin
            repeat (16) @(negedge sys_clk);
            csr_rd(ca(4'h0, 2'd2)); chk("stat_idx2", do4, 32'd2);
            csr_wr(ca(4'h0, 2'd0), 32'd1);
            csr_wr(ca(4'h0, 2'd1), 32'h00ABCDEF);
         end
      join
      repeat (4) @(negedge sys_clk);
      chk("words_ignore", exp_q.size(), 0);
      csr_rd(ca(4'h0, 2'd1)); chk("addr_readback", do4, 32'h00ABCDEF);

      // Abort during word 5
      push_words(1, 6);
      csr_wr(ca(4'h0, 2'd0), 32'd1);
      repeat (45) @(negedge sys_clk);
      csr_wr(ca(4'h0, 2'd0), 32'd2);
      chk("abort_ctrl", {28'd0, busy4, icap_clk4, ce_n4, wr_n4}, {28'd0, 4'b0011});
      chk("abort_data", {16'd0, icap_i4}, 32'h0000FFFF);
      csr_rd(ca(4'h0, 2'd0)); chk("abort_rd_ctrl", do4, 32'd0);
      chk("words_abort", exp_q.size(), 0);

      // Start and abort together from IDLE
      csr_wr(ca(4'h0, 2'd0), 32'd3);
      chk("start_abort_busy", {31'd0, busy4}, 32'd0);
      repeat (20) @(negedge sys_clk);
      chk("start_abort_ce_n", {31'd0, ce_n4}, 32'd1);
      csr_rd(ca(4'h0, 2'd0)); chk("start_abort_rd", do4, 32'd0);

      // Asynchronous reset during word 7
      push_words(1, 7);
      csr_wr(ca(4'h0, 2'd0), 32'd1);
      repeat (57) @(negedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      chk("arst_ctrl", {28'd0, busy4, icap_clk4, ce_n4, wr_n4}, {28'd0, 4'b0011});
      chk("arst_data", {16'd0, icap_i4}, 32'h0000FFFF);
      #1 sys_rst = 1'b0;
      chk("words_arst", exp_q.size(), 0);
      @(negedge sys_clk);
      csr_rd(ca(4'h0, 2'd1)); chk("arst_addr", do4, 32'd0);
      csr_wr(ca(4'h0, 2'd1), 32'h00123456);
      push_words(0, 13);
      csr_wr(ca(4'h0, 2'd0), 32'd1);
      count_busy4(n);
      chk("busy_len_rerun", n, 104);
      repeat (4) @(negedge sys_clk);
      chk("words_rerun", exp_q.size(), 0);

      // clk_div=1 instance in bank 3, and bank isolation
      csr_wr(ca(4'h3, 2'd0), 32'd1);
      chk("bank_no_start", {31'd0, busy4}, 32'd0);
      n = 0;
      tog_err = 0;
      while (busy1 && n < 200) begin
         if (icap_clk1 !== n[0]) tog_err++;
         n++;
         @(negedge sys_clk);
      end
      chk("busy_len_div1", n, 26);
      chk("toggle_div1", tog_err, 0);
      csr_rd(ca(4'h3, 2'd0));
      chk("div1_done", do1, 32'd2);
      chk("bank_rd_other", do4, 32'd0);
      csr_rd(ca(4'h0, 2'd1));
      chk("bank_rd_addr", do4, 32'h00123456);
      chk("bank_rd_unsel", do1, 32'd0);

      repeat (4) @(negedge sys_clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
